// File: rtl/dsp_pkg.sv
// Shared constants for the DSP front end: byte width and default SPI command FIFO depth.
package dsp_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned SPI_FIFO_DEPTH = 512;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port, no reset (block-RAM friendly).
module fifo_ram #(
  parameter int unsigned ENTRIES = 511,
  parameter int unsigned AW      = 9,
  parameter int unsigned DW      = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [ENTRIES];
  logic [DW-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_q <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/spi_cmd_fifo.sv
// Byte FIFO from the SPI slave to the DSP engine command port: RAM body, one-deep read stage,
// registered output byte, occupancy count and sticky overflow.
module spi_cmd_fifo
  import dsp_pkg::*;
#(
  parameter int unsigned DEPTH      = SPI_FIFO_DEPTH,
  parameter int unsigned DATA_WIDTH = BYTE_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   in_byte,
  input  logic                    in_valid,
  input  logic                    flush,
  output logic [DATA_WIDTH-1:0]   out_byte,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    overflow
);

  localparam int unsigned RAM_DEPTH = DEPTH - 1;
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned CW        = AW + 1;

  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW-1:0]         r_ram_cnt;
  logic                  r_stg_v;
  logic                  r_stg_byp;
  logic [DATA_WIDTH-1:0] r_byp;
  logic [DATA_WIDTH-1:0] r_out_byte;
  logic                  r_out_valid;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_overflow;

  logic [DATA_WIDTH-1:0] w_ram_q;
  logic [DATA_WIDTH-1:0] w_stg_data;
  logic                  w_pop;
  logic                  w_out_load;
  logic                  w_stg_free;
  logic                  w_wr_acc;
  logic                  w_wr_drop;
  logic                  w_ram_rd;
  logic                  w_ram_wr;
  logic                  w_byp;
  logic [AW-1:0]         w_wr_ptr_nxt;
  logic [AW-1:0]         w_rd_ptr_nxt;
  logic [AW-1:0]         w_ram_cnt_nxt;
  logic [CW-1:0]         w_count_nxt;

  // The stage holds the byte on its way to the output register: either the RAM read data or,
  // when the RAM is empty, a byte taken straight from the input so an empty FIFO has 2-cycle latency.
  always_comb begin
    w_pop         = r_out_valid && out_ready;
    w_out_load    = r_stg_v && (!r_out_valid || w_pop);
    w_stg_free    = !r_stg_v || w_out_load;
    w_wr_acc      = in_valid && !r_full && !flush;
    w_wr_drop     = in_valid && r_full && !flush;
    w_ram_rd      = w_stg_free && (r_ram_cnt != '0) && !flush;
    w_byp         = w_stg_free && (r_ram_cnt == '0) && w_wr_acc;
    w_ram_wr      = w_wr_acc && !w_byp;
    w_stg_data    = r_stg_byp ? r_byp : w_ram_q;
    w_wr_ptr_nxt  = (r_wr_ptr == AW'(RAM_DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
    w_rd_ptr_nxt  = (r_rd_ptr == AW'(RAM_DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
    w_ram_cnt_nxt = r_ram_cnt + AW'(w_ram_wr) - AW'(w_ram_rd);
    w_count_nxt   = r_count + CW'(w_wr_acc) - CW'(w_pop && !flush);
  end

  fifo_ram #(
    .ENTRIES (RAM_DEPTH),
    .AW      (AW),
    .DW      (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_byte),
    .i_re    (w_ram_rd),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_q)
  );

  // Pointers, RAM occupancy and read stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_stg_v   <= 1'b0;
      r_stg_byp <= 1'b0;
      r_byp     <= '0;
    end else if (flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_stg_v   <= 1'b0;
      r_stg_byp <= 1'b0;
    end else begin
      if (w_ram_wr) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_ram_rd) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      r_ram_cnt <= w_ram_cnt_nxt;
      if (w_ram_rd) begin
        r_stg_v   <= 1'b1;
        r_stg_byp <= 1'b0;
      end else if (w_byp) begin
        r_stg_v   <= 1'b1;
        r_stg_byp <= 1'b1;
        r_byp     <= in_byte;
      end else if (w_out_load) begin
        r_stg_v   <= 1'b0;
      end
    end
  end

  // Output register and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_byte  <= '0;
      r_out_valid <= 1'b0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_out_load) begin
        r_out_byte  <= w_stg_data;
        r_out_valid <= 1'b1;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      if (w_wr_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign out_byte  = r_out_byte;
  assign out_valid = r_out_valid;
  assign count     = r_count;
  assign full      = r_full;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_spi_cmd_fifo.sv
// Directed and scoreboard checks of spi_cmd_fifo at the default depth (A) and at depth 8 (B).
module tb_spi_cmd_fifo;

  logic       clk;
  logic       reset;

  logic [7:0] a_in_byte;
  logic       a_in_valid;
  logic       a_flush;
  logic       a_out_ready;
  logic [7:0] a_out_byte;
  logic       a_out_valid;
  logic [9:0] a_count;
  logic       a_full;
  logic       a_overflow;

  logic [7:0] b_in_byte;
  logic       b_in_valid;
  logic       b_flush;
  logic       b_out_ready;
  logic [7:0] b_out_byte;
  logic       b_out_valid;
  logic [3:0] b_count;
  logic       b_full;
  logic       b_overflow;

  int n_checks;
  int n_fail;

  spi_cmd_fifo u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_byte   (a_in_byte),
    .in_valid  (a_in_valid),
    .flush     (a_flush),
    .out_byte  (a_out_byte),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .count     (a_count),
    .full      (a_full),
    .overflow  (a_overflow)
  );

  spi_cmd_fifo #(.DEPTH(8)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_byte   (b_in_byte),
    .in_valid  (b_in_valid),
    .flush     (b_flush),
    .out_byte  (b_out_byte),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .count     (b_count),
    .full      (b_full),
    .overflow  (b_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] mq[$];
  int         mcnt;
  logic       mov;
  logic       iv;
  logic       rr;
  logic [7:0] bb;
  logic       popped;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    a_in_byte = '0; a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
    b_in_byte = '0; b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
    #1;
    check("rst_a_count", 32'(a_count), 0);
    check("rst_a_valid", 32'(a_out_valid), 0);
    check("rst_a_byte", 32'(a_out_byte), 0);
    check("rst_a_full", 32'(a_full), 0);
    check("rst_a_ovf", 32'(a_overflow), 0);
    check("rst_b_count", 32'(b_count), 0);
    #12 reset = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // 1: single byte, 2-cycle latency then pop
    a_in_byte = 8'hA5; a_in_valid = 1'b1; a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    check("t1_k1_count", 32'(a_count), 1);
    check("t1_k1_valid", 32'(a_out_valid), 0);
    step();
    check("t1_k2_valid", 32'(a_out_valid), 1);
    check("t1_k2_byte", 32'(a_out_byte), 32'h00A5);
    check("t1_k2_count", 32'(a_count), 1);
    step();
    check("t1_k3_count", 32'(a_count), 0);
    check("t1_k3_valid", 32'(a_out_valid), 0);
    check("t1_k3_hold", 32'(a_out_byte), 32'h00A5);

    // 2: 16-byte burst while stalled, then gapless drain
    a_out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a_in_byte = 8'(i); a_in_valid = 1'b1;
      step();
    end
    a_in_valid = 1'b0;
    check("t2_count16", 32'(a_count), 16);
    a_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t2_drain_valid", 32'(a_out_valid), 1);
      check("t2_drain_byte", 32'(a_out_byte), 32'(i));
      step();
    end
    check("t2_empty_valid", 32'(a_out_valid), 0);
    check("t2_empty_count", 32'(a_count), 0);

    // 5: flush mid-stream with simultaneous write and pop
    a_out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      a_in_byte = 8'(i); a_in_valid = 1'b1;
      step();
    end
    check("t5_count5", 32'(a_count), 5);
    a_flush = 1'b1; a_in_byte = 8'h77; a_in_valid = 1'b1; a_out_ready = 1'b1;
    step();
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    check("t5_fl_count", 32'(a_count), 0);
    check("t5_fl_valid", 32'(a_out_valid), 0);
    check("t5_fl_ovf", 32'(a_overflow), 0);
    step();
    check("t5_idle_valid", 32'(a_out_valid), 0);
    a_in_byte = 8'h3C; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    check("t5_3c_k1_valid", 32'(a_out_valid), 0);
    step();
    check("t5_3c_k2_valid", 32'(a_out_valid), 1);
    check("t5_3c_k2_byte", 32'(a_out_byte), 32'h003C);
    check("t5_3c_count", 32'(a_count), 1);

    // 3: overflow at depth 8
    b_out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t3_fill_count", 32'(b_count), (i < 8) ? 32'(i) : 32'd8);
      check("t3_fill_full", 32'(b_full), (i >= 8) ? 32'd1 : 32'd0);
      b_in_byte = 8'(8'h10 + i); b_in_valid = 1'b1;
      step();
    end
    b_in_valid = 1'b0;
    check("t3_full", 32'(b_full), 1);
    check("t3_ovf", 32'(b_overflow), 1);
    check("t3_count", 32'(b_count), 8);
    b_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t3_drain_valid", 32'(b_out_valid), 1);
      check("t3_drain_byte", 32'(b_out_byte), 32'(8'h10 + i));
      step();
    end
    check("t3_empty_valid", 32'(b_out_valid), 0);
    check("t3_ovf_sticky", 32'(b_overflow), 1);
    b_out_ready = 1'b0;
    b_flush = 1'b1;
    step();
    b_flush = 1'b0;
    check("t3_flush_ovf", 32'(b_overflow), 0);
    check("t3_flush_count", 32'(b_count), 0);

    // 4: full, write and pop in the same cycle
    for (int i = 0; i < 8; i++) begin
      b_in_byte = 8'(8'h20 + i); b_in_valid = 1'b1;
      step();
    end
    check("t4_full", 32'(b_full), 1);
    check("t4_head", 32'(b_out_byte), 32'h0020);
    b_in_byte = 8'h99; b_in_valid = 1'b1; b_out_ready = 1'b1;
    step();
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    check("t4_count7", 32'(b_count), 7);
    check("t4_ovf", 32'(b_overflow), 1);
    check("t4_not_full", 32'(b_full), 0);
    b_out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check("t4_drain_valid", 32'(b_out_valid), 1);
      check("t4_drain_byte", 32'(b_out_byte), 32'(8'h20 + i));
      step();
    end
    check("t4_empty_valid", 32'(b_out_valid), 0);
    b_out_ready = 1'b0;

    // 6: asynchronous reset between edges with 3 bytes queued in A
    a_in_byte = 8'h41; a_in_valid = 1'b1;
    step();
    a_in_byte = 8'h42;
    step();
    a_in_valid = 1'b0;
    check("t6_count3", 32'(a_count), 3);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_valid", 32'(a_out_valid), 0);
    check("t6_rst_byte", 32'(a_out_byte), 0);
    check("t6_rst_count", 32'(a_count), 0);
    #2 reset = 1'b0;
    step();
    check("t6_post_valid", 32'(a_out_valid), 0);
    check("t6_post_count", 32'(a_count), 0);
    a_in_byte = 8'h5A; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    step();
    check("t6_post_byte", 32'(a_out_byte), 32'h005A);
    check("t6_post_v", 32'(a_out_valid), 1);

    // Random write/pop scoreboard on the depth-8 instance
    mq.delete();
    mcnt = 0;
    mov  = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      check("rnd_count", 32'(b_count), 32'(mcnt));
      check("rnd_full", 32'(b_full), (mcnt == 8) ? 32'd1 : 32'd0);
      check("rnd_ovf", 32'(b_overflow), 32'(mov));
      iv = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      bb = 8'($urandom);
      popped = 1'b0;
      if (b_out_valid && rr) begin
        check("rnd_nonempty", (mq.size() != 0) ? 32'd1 : 32'd0, 1);
        if (mq.size() != 0) check("rnd_data", 32'(b_out_byte), 32'(mq.pop_front()));
        popped = 1'b1;
      end
      if (iv) begin
        if (mcnt == 8) mov = 1'b1;
        else mq.push_back(bb);
      end
      mcnt = mq.size();
      b_in_valid = iv; b_in_byte = bb; b_out_ready = rr;
      step();
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (b_out_valid) begin
        check("rnd_drain_nonempty", (mq.size() != 0) ? 32'd1 : 32'd0, 1);
        if (mq.size() != 0) check("rnd_drain_data", 32'(b_out_byte), 32'(mq.pop_front()));
      end
      step();
    end
    check("rnd_left", 32'(mq.size()), 0);
    check("rnd_end_count", 32'(b_count), 0);
    check("rnd_end_valid", 32'(b_out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
